hyst_pack_fifo: RTL and testbench

//  Single-clock FIFO with narrow-to-wide packing and hysteresis gating on both sides.

---
 rtl/hyst_fifo_pkg.sv | 17 +
 rtl/hyst_fifo_ram.sv | 25 ++
 rtl/hyst_pack_fifo.sv | 187 ++++++++++++++++++
 tb/tb_hyst_pack_fifo.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyst_fifo_pkg.sv
// Shared types and sizing helpers for the hysteresis packing FIFO.
package hyst_fifo_pkg;

    typedef enum logic {PUSH_ON, PUSH_DROP} push_state_t;
    typedef enum logic {POP_WAIT, POP_ON}   pop_state_t;

    // Lane counter width; a 1:1 ratio still needs one bit to hold lane 0.
    function automatic int lane_bits(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    // Level/pointer width: one extra bit so a full FIFO reads as DEPTH, not 0.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hyst_fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
module hyst_fifo_ram #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; pointers guard stale contents.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/hyst_pack_fifo.sv
// Narrow-to-wide packing FIFO with hysteresis on push (frame re-arm) and pop (start level).
// Define HYST_FIFO_STATS_EN to add the saturating drop_cnt / unf_cnt statistics ports.
module hyst_pack_fifo
    import hyst_fifo_pkg::*;
#(
    parameter int IN_W        = 8,
    parameter int RATIO       = 4,
    parameter int DEPTH       = 2048,
    parameter int PUSH_RESUME = DEPTH / 2,
    parameter int POP_START   = DEPTH / 2,
    parameter int DCNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IN_W-1:0]           s_tdata,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    input  logic                      s_tlast,
    output logic [IN_W*RATIO-1:0]     m_tdata,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [lvl_w(DEPTH)-1:0]   level,
    output logic                      overflow,
    output logic                      underflow
`ifdef HYST_FIFO_STATS_EN
    ,
    output logic [DCNT_W-1:0]         drop_cnt,
    output logic [DCNT_W-1:0]         unf_cnt
`endif
);

    localparam int OUT_W  = IN_W * RATIO;
    localparam int LVL_W  = lvl_w(DEPTH);
    localparam int PTR_W  = LVL_W - 1;
    localparam int LANE_W = lane_bits(RATIO);

    logic [LVL_W-1:0]  r_wr_ptr, r_wr_vis, r_rd_ptr;
    logic [LANE_W-1:0] r_lane;
    logic [OUT_W-1:0]  r_word;
    push_state_t       r_push_state;
    pop_state_t        r_pop_state;
    logic              r_overflow, r_underflow;

    logic [LVL_W-1:0]  w_count, w_level, w_rd_next, w_level_next;
    logic [OUT_W-1:0]  w_wdata, w_rdata;
    logic              w_full, w_empty, w_allow_push, w_allow_pop;
    logic              w_accept, w_commit, w_pop, w_ovf_evt, w_unf_evt;

    // Full uses every committed word, so a commit can never overwrite the head even
    // when the reported level still lags the write by a cycle.
    assign w_count      = r_wr_ptr - r_rd_ptr;
    assign w_level      = r_wr_vis - r_rd_ptr;
    assign w_full       = (w_count == LVL_W'(DEPTH));
    assign w_empty      = (w_level == '0);
    assign w_allow_push = (r_push_state == PUSH_ON);
    assign w_allow_pop  = (r_pop_state == POP_ON);

    assign s_tready  = w_allow_push & ~w_full;
    assign m_tvalid  = w_allow_pop & ~w_empty;
    assign m_tdata   = w_allow_pop ? w_rdata : '0;
    assign level     = w_level;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    assign w_accept     = s_tvalid & s_tready;
    assign w_commit     = w_accept & ((r_lane == LANE_W'(RATIO - 1)) | s_tlast);
    assign w_pop        = m_tvalid & m_tready;
    assign w_rd_next    = r_rd_ptr + LVL_W'(w_pop);
    assign w_level_next = r_wr_ptr - w_rd_next;
    assign w_wdata      = r_word | (OUT_W'(s_tdata) << (r_lane * IN_W));
    assign w_ovf_evt    = w_allow_push & s_tvalid & w_full;
    assign w_unf_evt    = w_allow_pop & (w_level_next == '0) & (POP_START != 0);

    // NOTE: sequential state uses non-blocking assignments so every block samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (w_ovf_evt || w_commit) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (w_accept) begin
            r_lane <= r_lane + LANE_W'(1);
            r_word <= w_wdata;
        end
    end

    // r_wr_vis trails the write pointer so level and the registered read agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_wr_vis <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_commit) begin
                r_wr_ptr <= r_wr_ptr + LVL_W'(1);
            end
            r_wr_vis <= r_wr_ptr;
            r_rd_ptr <= w_rd_next;
        end
    end

    hyst_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (OUT_W),
        .AW    (PTR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_commit),
        .i_waddr (r_wr_ptr[PTR_W-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (w_rd_next[PTR_W-1:0]),
        .o_rdata (w_rdata)
    );

    // The tlast beat that re-arms push is itself dropped (s_tready was low).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_push_state <= PUSH_ON;
            r_overflow   <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            case (r_push_state)
                PUSH_ON: begin
                    if (w_ovf_evt) begin
                        r_push_state <= PUSH_DROP;
                        r_overflow   <= 1'b1;
                    end
                end
                PUSH_DROP: begin
                    if (s_tvalid && s_tlast && (w_level <= LVL_W'(PUSH_RESUME))) begin
                        r_push_state <= PUSH_ON;
                    end
                end
                default: r_push_state <= PUSH_ON;
            endcase
        end
    end

    // Gates look at the post-edge level so m_tvalid moves in the same cycle as level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pop_state <= POP_WAIT;
            r_underflow <= 1'b0;
        end else begin
            r_underflow <= 1'b0;
            case (r_pop_state)
                POP_WAIT: begin
                    if (w_level_next >= LVL_W'(POP_START)) begin
                        r_pop_state <= POP_ON;
                    end
                end
                POP_ON: begin
                    if (w_unf_evt) begin
                        r_pop_state <= POP_WAIT;
                        r_underflow <= 1'b1;
                    end
                end
                default: r_pop_state <= POP_WAIT;
            endcase
        end
    end

`ifdef HYST_FIFO_STATS_EN
    logic [DCNT_W-1:0] r_drop_cnt, r_unf_cnt;
    logic              w_drop;

    assign w_drop   = s_tvalid & ~s_tready;
    assign drop_cnt = r_drop_cnt;
    assign unf_cnt  = r_unf_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
            r_unf_cnt  <= '0;
        end else begin
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + DCNT_W'(1);
            end
            if (w_unf_evt && (r_unf_cnt != '1)) begin
                r_unf_cnt <= r_unf_cnt + DCNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hyst_pack_fifo.sv
// Self-checking bench for hyst_pack_fifo: directed table, hand sequences and a random run
// against a queue-based reference model.
module tb_hyst_pack_fifo;

    localparam int IN_W        = 8;
    localparam int RATIO       = 4;
    localparam int DEPTH       = 16;
    localparam int PUSH_RESUME = 8;
    localparam int POP_START   = 8;
    localparam int DCNT_W      = 16;
    localparam int DMAX        = (1 << DCNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tlast, m_tready;
    logic        s_tready, m_tvalid, overflow, underflow;
    logic [31:0] m_tdata;
    logic [4:0]  level;
`ifdef HYST_FIFO_STATS_EN
    logic [15:0] drop_cnt, unf_cnt;
`endif

    hyst_pack_fifo #(
        .IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH),
        .PUSH_RESUME(PUSH_RESUME), .POP_START(POP_START), .DCNT_W(DCNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .level(level), .overflow(overflow), .underflow(underflow)
`ifdef HYST_FIFO_STATS_EN
        , .drop_cnt(drop_cnt), .unf_cnt(unf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: committed words in a queue, the newest one hidden for a cycle.
    logic [31:0] q[$];
    logic [7:0]  part[$];
    int          hidden;
    bit          m_push_on, m_pop_on, m_ovf, m_unf;
    int          m_drop, m_unf_cnt;

    typedef struct {
        int          n;
        logic [31:0] bytes;
        logic        last;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        part.delete();
        hidden    = 0;
        m_push_on = 1;
        m_pop_on  = 0;
        m_ovf     = 0;
        m_unf     = 0;
        m_drop    = 0;
        m_unf_cnt = 0;
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d, input bit last, input bit rdy);
        int          lvl, lvl_new;
        bit          full, trdy, commit;
        logic [31:0] w;
        lvl    = q.size() - hidden;
        full   = (q.size() == DEPTH);
        trdy   = m_push_on && !full;
        commit = 0;
        if (m_pop_on && lvl > 0 && rdy) void'(q.pop_front());
        if (v && trdy) begin
            part.push_back(d);
            if (part.size() == RATIO || last) begin
                w = '0;
                foreach (part[k]) w = w | (32'(part[k]) << (8 * k));
                q.push_back(w);
                part.delete();
                commit = 1;
            end
        end
        if (v && !trdy && m_drop < DMAX) m_drop++;
        m_ovf = 0;
        if (m_push_on && v && full) begin
            m_push_on = 0;
            m_ovf     = 1;
            part.delete();
        end else if (!m_push_on && v && last && lvl <= PUSH_RESUME) begin
            m_push_on = 1;
        end
        hidden  = commit ? 1 : 0;
        lvl_new = q.size() - hidden;
        m_unf   = 0;
        if (!m_pop_on) begin
            if (lvl_new >= POP_START) m_pop_on = 1;
        end else if (lvl_new == 0 && POP_START > 0) begin
            m_pop_on = 0;
            m_unf    = 1;
            if (m_unf_cnt < DMAX) m_unf_cnt++;
        end
    endtask

    task automatic compare();
        int exp_level;
        bit exp_mv;
        exp_level = q.size() - hidden;
        exp_mv    = m_pop_on && exp_level > 0;
        check("level", level, exp_level);
        check("s_tready", s_tready, m_push_on && q.size() != DEPTH);
        check("m_tvalid", m_tvalid, exp_mv);
        if (exp_mv)         check("m_tdata", m_tdata, q[0]);
        else if (!m_pop_on) check("m_tdata_idle", m_tdata, 0);
        check("overflow", overflow, m_ovf);
        check("underflow", underflow, m_unf);
`ifdef HYST_FIFO_STATS_EN
        check("drop_cnt", drop_cnt, m_drop);
        check("unf_cnt", unf_cnt, m_unf_cnt);
`endif
    endtask

    // Called at a falling edge: drive, check pre-edge outputs, advance model, return at next fall.
    task automatic step(input bit v, input logic [7:0] d, input bit last, input bit rdy);
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = last;
        m_tready = rdy;
        #1;
        compare();
        @(posedge clk);
        model_edge(v, d, last, rdy);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        #1;
        model_reset();
        check("rst_level", level, 0);
        check("rst_s_tready", s_tready, 1);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_pulses", {overflow, underflow}, 0);
`ifdef HYST_FIFO_STATS_EN
        check("rst_counters", {drop_cnt, unf_cnt}, 0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lvl_max, pops, beat;

        tbl[0] = '{4, 32'h04030201, 1'b0, 32'h04030201};
        tbl[1] = '{4, 32'h08070605, 1'b1, 32'h08070605};
        tbl[2] = '{2, 32'hEEFFBBAA, 1'b1, 32'h0000BBAA};
        tbl[3] = '{4, 32'h44332211, 1'b0, 32'h44332211};
        tbl[4] = '{1, 32'hDDCCBB5A, 1'b1, 32'h0000005A};
        tbl[5] = '{3, 32'h99C3C2C1, 1'b1, 32'h00C3C2C1};
        tbl[6] = '{4, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
        tbl[7] = '{4, 32'h12345678, 1'b0, 32'h12345678};

        // Packing, short frames and pop arming at exactly POP_START words.
        do_reset();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < tbl[i].n; j++)
                step(1, tbl[i].bytes[8*j +: 8], tbl[i].last && (j == tbl[i].n - 1), 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("t1_level", level, 8);
        check("t1_armed", m_tvalid, 1);
        for (int i = 0; i < 8; i++) begin
            check("t1_word", m_tdata, tbl[i].exp);
            step(0, 0, 0, 1);
        end
        check("t1_underflow", underflow, 1);
        check("t1_disarmed", {m_tvalid, m_tdata}, 0);
        step(0, 0, 0, 0);
        check("t1_unf_pulse_end", underflow, 0);

        // Reset mid-frame, then 32 bytes: m_tvalid rises two cycles after the 8th commit.
        step(1, 8'hF1, 0, 0);
        step(1, 8'hF2, 0, 0);
        do_reset();
        for (int i = 0; i < 32; i++) step(1, 8'(i + 1), 0, 0);
        check("t2_not_yet", m_tvalid, 0);
        step(0, 0, 0, 0);
        check("t2_armed", m_tvalid, 1);
        check("t6_clean_word", m_tdata, 32'h04030201);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
        check("t2_underflow", underflow, 1);

        // Overflow, drop until a tlast at or below PUSH_RESUME, then clean restart.
        do_reset();
        for (int i = 0; i < 64; i++) step(1, 8'(i), 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("t3_full_level", level, 16);
        check("t3_full_tready", s_tready, 0);
        step(1, 8'h90, 0, 0);
        check("t3_overflow", overflow, 1);
        for (int i = 1; i < 4; i++) step(1, 8'(8'h90 + i), 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
        check("t3_drained", level, 8);
        step(1, 8'h77, 1, 0);
        check("t3_rearm", s_tready, 1);
        for (int i = 0; i < 4; i++) step(1, 8'(8'hA1 + i), 0, 0);
`ifdef HYST_FIFO_STATS_EN
        check("t3_drop_cnt", drop_cnt, 5);
`endif
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
        check("t3_new_word", m_tdata, 32'hA4A3A2A1);
        step(0, 0, 0, 1);

        // Saturated FIFO with streaming input and popping; several pointer laps.
        do_reset();
        lvl_max = 0;
        pops    = 0;
        beat    = 0;
        for (int lap = 0; lap < 4; lap++) begin
            for (int c = 0; c < 120; c++) begin
                if (m_tvalid && c >= 80) pops++;
                step(1, 8'($urandom), (beat % 4) == 3, c >= 80);
                beat++;
                if (int'(level) > lvl_max) lvl_max = int'(level);
            end
        end
        check("t5_level_max", lvl_max, 16);
        check("t5_laps", pops >= 3 * DEPTH, 1);

        // Randomized traffic in regimes of differing load.
        do_reset();
        for (int blk = 0; blk < 20; blk++) begin
            int pv, pr, pl;
            pv = $urandom_range(100, 20);
            pr = $urandom_range(100, 5);
            pl = $urandom_range(8, 1);
            for (int c = 0; c < 100; c++)
                step($urandom_range(99) < pv, 8'($urandom), $urandom_range(pl - 1) == 0,
                     $urandom_range(99) < pr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
